// File: rtl/ahb_mux_if.sv
// rtl/ahb_mux_if.sv - Bus bundle between the AHB decoder/slaves/master and the data-phase response mux.
interface ahb_mux_if #(
   parameter int SLV_NUMBER = 16,
   parameter int DATA_WIDTH = 32
);
   localparam int SW = (SLV_NUMBER > 1) ? $clog2(SLV_NUMBER) : 1;

   logic [1:0]                       m_htrans_i;
   logic [SLV_NUMBER-1:0]            s_hsel_i;
   logic [SW-1:0]                    s_hslave_i;
   logic [SLV_NUMBER-1:0]            s_hreadyout_i;
   logic [SLV_NUMBER-1:0]            s_hresp_i;
   logic [SLV_NUMBER*DATA_WIDTH-1:0] s_hrdata_i;
   logic                             m_hready_o;
   logic                             m_hresp_o;
   logic [DATA_WIDTH-1:0]            m_hrdata_o;

   // The mux itself sits on the slave side of this bundle.
   modport slave (
      input  m_htrans_i, s_hsel_i, s_hslave_i, s_hreadyout_i, s_hresp_i, s_hrdata_i,
      output m_hready_o, m_hresp_o, m_hrdata_o
   );

   modport master (
      output m_htrans_i, s_hsel_i, s_hslave_i, s_hreadyout_i, s_hresp_i, s_hrdata_i,
      input  m_hready_o, m_hresp_o, m_hrdata_o
   );
endinterface

// File: rtl/ahb_mux.sv
// rtl/ahb_mux.sv - AHB data-phase response mux with optional default slave (AHB_MUX_DEFAULT_SLAVE_EN).
// Captures the decoder select on each accepted address phase and forwards that slave's response.
module ahb_mux #(
   parameter int SLV_NUMBER = 16,
   parameter int DATA_WIDTH = 32
) (
   input  logic       clk_i,
   input  logic       rst_i,
   ahb_mux_if.slave   bus
);
   localparam int SW = (SLV_NUMBER > 1) ? $clog2(SLV_NUMBER) : 1;

   logic                  dp_hit;
   logic [SW-1:0]         dp_slave;
   logic                  accept;
   logic                  ds_hready;
   logic                  ds_hresp;
   logic                  sel_hready;
   logic                  sel_hresp;
   logic [DATA_WIDTH-1:0] sel_hrdata;

   assign accept = bus.m_hready_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dp_hit   <= 1'b0;
         dp_slave <= '0;
      end else if (accept) begin
         dp_hit   <= |bus.s_hsel_i;
         dp_slave <= bus.s_hslave_i;
      end
   end

   // Index outside the populated slave range falls back to a zero-wait OKAY.
   always_comb begin
      sel_hready = 1'b1;
      sel_hresp  = 1'b0;
      sel_hrdata = '0;
      for (int i = 0; i < SLV_NUMBER; i++) begin
         if (dp_slave == SW'(i)) begin
            sel_hready = bus.s_hreadyout_i[i];
            sel_hresp  = bus.s_hresp_i[i];
            sel_hrdata = bus.s_hrdata_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

`ifdef AHB_MUX_DEFAULT_SLAVE_EN
   typedef enum logic [1:0] {
      DS_OKAY = 2'd0,
      DS_ERR1 = 2'd1,
      DS_ERR2 = 2'd2
   } ds_state_t;

   ds_state_t ds_state;
   ds_state_t ds_next;
   logic      unused_htrans;

   assign unused_htrans = bus.m_htrans_i[0];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ds_state <= DS_OKAY;
      end else begin
         ds_state <= ds_next;
      end
   end

   // ERR2 completes the transfer, so it accepts the next address phase like OKAY.
   always_comb begin
      ds_next = ds_state;
      case (ds_state)
         DS_ERR1: ds_next = DS_ERR2;
         default: begin
            if (accept) begin
               ds_next = (!(|bus.s_hsel_i) && bus.m_htrans_i[1]) ? DS_ERR1 : DS_OKAY;
            end
         end
      endcase
   end

   always_comb begin
      ds_hready = 1'b1;
      ds_hresp  = 1'b0;
      case (ds_state)
         DS_ERR1: begin
            ds_hready = 1'b0;
            ds_hresp  = 1'b1;
         end
         DS_ERR2: begin
            ds_hready = 1'b1;
            ds_hresp  = 1'b1;
         end
         default: begin
            ds_hready = 1'b1;
            ds_hresp  = 1'b0;
         end
      endcase
   end
`else
   logic [1:0] unused_htrans;

   assign unused_htrans = bus.m_htrans_i;
   assign ds_hready     = 1'b1;
   assign ds_hresp      = 1'b0;
`endif

   always_comb begin
      if (dp_hit) begin
         bus.m_hready_o = sel_hready;
         bus.m_hresp_o  = sel_hresp;
         bus.m_hrdata_o = sel_hrdata;
      end else begin
         bus.m_hready_o = ds_hready;
         bus.m_hresp_o  = ds_hresp;
         bus.m_hrdata_o = '0;
      end
   end
endmodule
